// File: rtl/vco_sweep_if.sv
// Bundles the sweep controller's signals: config/CSR side, VCO core side and point-record side.
// The master modport is the controller's view; slave is the view from the surrounding logic.
interface vco_sweep_if #(
    parameter int W_W   = 17,
    parameter int OUT_W = 14,
    parameter int CNT_W = 16
);
    logic                    start;
    logic                    abort;
    logic [W_W-1:0]          cfg_w_start;
    logic [W_W-1:0]          cfg_w_end;
    logic [W_W-1:0]          cfg_w_inc;
    logic [CNT_W-1:0]        cfg_div;
    logic [CNT_W-1:0]        cfg_dwell;
    logic signed [OUT_W-1:0] core_out;
    logic                    core_step;
    logic                    core_reset;
    logic [W_W-1:0]          core_w;
    logic                    pt_valid;
    logic                    pt_ready;
    logic [W_W-1:0]          pt_w;
    logic [OUT_W-2:0]        pt_peak;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, abort, cfg_w_start, cfg_w_end, cfg_w_inc, cfg_div, cfg_dwell,
               core_out, pt_ready,
        output core_step, core_reset, core_w, pt_valid, pt_w, pt_peak, busy, done
    );

    modport slave (
        output start, abort, cfg_w_start, cfg_w_end, cfg_w_inc, cfg_div, cfg_dwell,
               core_out, pt_ready,
        input  core_step, core_reset, core_w, pt_valid, pt_w, pt_peak, busy, done
    );
endinterface

// File: rtl/vco_sweep_ctrl.sv
// Frequency-sweep sequencer for one VCO integrator core. For each frequency word it
// (re)initialises the core, steps it cfg_dwell times at one step per cfg_div clocks,
// tracks peak |core_out|, and hands a (w, peak) record out over valid/ready.
module vco_sweep_ctrl #(
    parameter int W_W    = 17,
    parameter int OUT_W  = 14,
    parameter int CNT_W  = 16,
    parameter bit RESEED = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    vco_sweep_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RUN, S_REPORT, S_NEXT, S_FIN
    } state_t;

    state_t           state_q;
    logic [W_W-1:0]   w_end_q, w_inc_q, core_w_q, pt_w_q;
    logic [CNT_W-1:0] div_q, dwell_q, div_cnt_q, steps_q;
    logic [OUT_W-2:0] peak_q, pt_peak_q;
    logic             core_step_q, core_reset_q, samp_q, pt_valid_q, busy_q, done_q;

    logic [OUT_W-1:0] neg_x;
    logic [OUT_W-2:0] abs_x, peak_d;
    logic [W_W:0]     nxt_d;
    logic             last_d;

    // |core_out| with the most negative code saturated, running peak, and next-word / end-of-sweep test
    always_comb begin
        neg_x = ~bus.core_out + 1'b1;
        if (!bus.core_out[OUT_W-1])  abs_x = bus.core_out[OUT_W-2:0];
        else if (neg_x[OUT_W-1])     abs_x = '1;
        else                         abs_x = neg_x[OUT_W-2:0];
        peak_d = (samp_q && (abs_x > peak_q)) ? abs_x : peak_q;
        // extra bit catches wrap-around of the frequency word
        nxt_d  = {1'b0, core_w_q} + {1'b0, w_inc_q};
        last_d = (w_inc_q == '0) || nxt_d[W_W] || (nxt_d[W_W-1:0] > w_end_q);
    end

    // Sweep FSM; all outputs registered. core_step is scheduled one cycle ahead so it
    // lands on the last cycle of each div-cycle window, the first one div cycles after RUN entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            w_end_q      <= '0;
            w_inc_q      <= '0;
            core_w_q     <= '0;
            pt_w_q       <= '0;
            div_q        <= '0;
            dwell_q      <= '0;
            div_cnt_q    <= '0;
            steps_q      <= '0;
            peak_q       <= '0;
            pt_peak_q    <= '0;
            core_step_q  <= 1'b0;
            core_reset_q <= 1'b0;
            samp_q       <= 1'b0;
            pt_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (bus.abort && (state_q != S_IDLE)) begin
            // abort drops everything in flight, including a pending record
            state_q      <= S_IDLE;
            core_step_q  <= 1'b0;
            core_reset_q <= 1'b0;
            samp_q       <= 1'b0;
            pt_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            core_step_q  <= 1'b0;
            core_reset_q <= 1'b0;
            done_q       <= 1'b0;
            samp_q       <= core_step_q;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        w_end_q      <= bus.cfg_w_end;
                        w_inc_q      <= bus.cfg_w_inc;
                        div_q        <= (bus.cfg_div == '0) ? CNT_W'(1) : bus.cfg_div;
                        dwell_q      <= (bus.cfg_dwell == '0) ? CNT_W'(1) : bus.cfg_dwell;
                        core_w_q     <= bus.cfg_w_start;
                        core_reset_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_INIT;
                    end
                end
                S_INIT: begin
                    peak_q    <= '0;
                    div_cnt_q <= '0;
                    steps_q   <= '0;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    peak_q <= peak_d;
                    if (steps_q != dwell_q) begin
                        if (div_cnt_q == div_q - CNT_W'(1)) begin
                            core_step_q <= 1'b1;
                            div_cnt_q   <= '0;
                            steps_q     <= steps_q + CNT_W'(1);
                        end else begin
                            div_cnt_q   <= div_cnt_q + CNT_W'(1);
                        end
                    end
                    // sample of the final step: no step in flight and all steps issued
                    if (samp_q && !core_step_q && (steps_q == dwell_q)) begin
                        pt_valid_q <= 1'b1;
                        pt_w_q     <= core_w_q;
                        pt_peak_q  <= peak_d;
                        state_q    <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (bus.pt_ready) begin
                        pt_valid_q <= 1'b0;
                        done_q     <= last_d;
                        state_q    <= last_d ? S_FIN : S_NEXT;
                    end
                end
                S_NEXT: begin
                    core_w_q  <= nxt_d[W_W-1:0];
                    peak_q    <= '0;
                    div_cnt_q <= '0;
                    steps_q   <= '0;
                    if (RESEED) begin
                        core_reset_q <= 1'b1;
                        state_q      <= S_INIT;
                    end else begin
                        state_q      <= S_RUN;
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.core_step  = core_step_q;
    assign bus.core_reset = core_reset_q;
    assign bus.core_w     = core_w_q;
    assign bus.pt_valid   = pt_valid_q;
    assign bus.pt_w       = pt_w_q;
    assign bus.pt_peak    = pt_peak_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
